// File: rtl/pipe_ctrl.sv
// Hazard resolver for the 5-stage core: turns stall/flush causes into per-register hold and flush vectors.
// Optional perf counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter int unsigned RST_CYC    = 4,
    parameter int unsigned DRAIN_CYC  = 2,
    parameter int unsigned MC_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_use_i,
    input  logic        ex_start_i,
    input  logic        ex_done_i,
    input  logic        mem_wait_i,
    input  logic        br_taken_i,
    input  logic        exc_i,
    output logic [4:0]  hold_o,
    output logic [4:0]  flush_o,
    output logic        mc_timeout_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_RUN   = 2'd1,
        ST_MC    = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam logic [7:0] RST_LAST   = 8'(RST_CYC - 1);
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYC - 1);
    localparam logic [7:0] TO_LAST    = 8'(MC_TIMEOUT - 1);

    localparam logic [4:0] V_NONE    = 5'b00000;
    localparam logic [4:0] V_PC      = 5'b00001;
    localparam logic [4:0] V_TRAP    = 5'b11110;
    localparam logic [4:0] V_DRAIN   = 5'b01110;
    localparam logic [4:0] V_MW_HOLD = 5'b01111;
    localparam logic [4:0] V_MW_FL   = 5'b10000;
    localparam logic [4:0] V_MC_HOLD = 5'b00111;
    localparam logic [4:0] V_MC_FL   = 5'b01000;
    localparam logic [4:0] V_BR_FL   = 5'b00110;
    localparam logic [4:0] V_LU_HOLD = 5'b00011;
    localparam logic [4:0] V_LU_FL   = 5'b00100;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       done_pend_q, done_pend_d;
    logic [4:0] hold_s, flush_s;
    logic       mc_timeout_s;
    logic       mc_stall_s;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        sat_inc = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Next-state, counter and output decode; priority order exc > mem_wait > MC wait > branch > load-use.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        done_pend_d  = done_pend_q;
        hold_s       = V_NONE;
        flush_s      = V_NONE;
        mc_timeout_s = 1'b0;
        mc_stall_s   = (state_q == ST_MC) && !ex_done_i && !done_pend_q && (cnt_q != TO_LAST);
        case (state_q)
            ST_RST: begin
                hold_s  = V_PC;
                flush_s = V_TRAP;
                if (cnt_q == RST_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_RUN, ST_MC: begin
                if (exc_i) begin
                    flush_s     = V_TRAP;
                    state_d     = ST_DRAIN;
                    cnt_d       = 8'd0;
                    done_pend_d = 1'b0;
                end else if (mem_wait_i) begin
                    // cnt frozen; a done seen here is remembered and retires MC later
                    hold_s  = V_MW_HOLD;
                    flush_s = V_MW_FL;
                    if ((state_q == ST_MC) && ex_done_i) begin
                        done_pend_d = 1'b1;
                    end else begin
                        done_pend_d = done_pend_q;
                    end
                end else if (mc_stall_s) begin
                    hold_s  = V_MC_HOLD;
                    flush_s = V_MC_FL;
                    cnt_d   = sat_inc(cnt_q);
                end else begin
                    if (state_q == ST_MC) begin
                        state_d      = ST_RUN;
                        cnt_d        = 8'd0;
                        done_pend_d  = 1'b0;
                        mc_timeout_s = !ex_done_i && !done_pend_q;
                    end else if (ex_start_i) begin
                        state_d = ST_MC;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = ST_RUN;
                    end
                    if (br_taken_i) begin
                        flush_s = V_BR_FL;
                    end else if (ld_use_i) begin
                        hold_s  = V_LU_HOLD;
                        flush_s = V_LU_FL;
                    end else begin
                        hold_s  = V_NONE;
                        flush_s = V_NONE;
                    end
                end
            end
            ST_DRAIN: begin
                flush_s = V_DRAIN;
                if (exc_i) begin
                    cnt_d = 8'd0;
                end else if (cnt_q == DRAIN_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d     = ST_RST;
                cnt_d       = 8'd0;
                done_pend_d = 1'b0;
                hold_s      = V_PC;
                flush_s     = V_TRAP;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RST;
            cnt_q       <= 8'd0;
            done_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_pend_q <= done_pend_d;
        end
    end

    assign hold_o       = hold_s;
    assign flush_o      = flush_s;
    assign mc_timeout_o = mc_timeout_s;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic        stall_evt_s, flush_evt_s;

    // Perf increments; in RUN/MC only a trap or taken branch produces these two flush patterns.
    always_comb begin
        stall_evt_s = (state_q != ST_RST) && (|hold_s);
        flush_evt_s = ((state_q == ST_RUN) || (state_q == ST_MC)) &&
                      ((flush_s == V_TRAP) || (flush_s == V_BR_FL));
        if (stall_evt_s) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush_evt_s) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Perf counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = 32'd0;
    assign flush_cnt_o = 32'd0;
`endif

endmodule
